// File: rtl/des_pkg.sv
// DES tables, bit permutations and sequencer state encoding.
// Purely combinational helpers: no latency, no flow control.
// Table entries number bits from 1 = MSB of the vector, as in the published DES tables.
package des_pkg;

    localparam logic [15:0] SHIFT_SCHED = 16'b1000000100000011;
    localparam int          NUM_ROUNDS  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    localparam int FP_TBL [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25
    };

    // Each box is row-major: entry index = {row, col}.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [1:0] s(input logic [15:0] sched, input logic [3:0] i);
        return sched[i] ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [47:0] expansion(input logic [31:0] r);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47 - i] = r[32 - E_TBL[i]];
        return o;
    endfunction

    function automatic logic [31:0] s_function(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  six;
        o   = '0;
        six = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47 - 6*b -: 6];
            o[31 - 4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
        end
        return o;
    endfunction

    function automatic logic [31:0] p_post_sf(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31 - i] = x[32 - P_TBL[i]];
        return o;
    endfunction

    function automatic logic [47:0] p_key2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47 - i] = cd[56 - PC2_TBL[i]];
        return o;
    endfunction

    function automatic logic [63:0] p_inverse(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63 - i] = x[64 - FP_TBL[i]];
        return o;
    endfunction

endpackage

// File: rtl/des_round_f.sv
// DES round function F(R, K) = P(S(E(R) ^ K)).
// Combinational, zero latency; no flow control.
// Used once per clock by the iterative sequencer.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] mixed;

    always_comb begin
        mixed = expansion(r) ^ k;
        f     = p_post_sf(s_function(mixed));
    end

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES engine: one Feistel round per clock through a shared round datapath.
// Latency 16 cycles from accept to out_valid; one block in flight, next accept after the out handshake.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE or while abort is high.
module des_round_sequencer #(
    parameter logic [15:0] SHIFT_SCHED = des_pkg::SHIFT_SCHED,
    parameter int          NUM_ROUNDS  = des_pkg::NUM_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in,
    input  logic [55:0] key,
    input  logic        decrypt,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out,
    output logic        busy,
    output logic [3:0]  round_idx
);

    import des_pkg::state_t;
    import des_pkg::IDLE;
    import des_pkg::RUN;
    import des_pkg::DONE;
    import des_pkg::s;
    import des_pkg::rotl28;
    import des_pkg::rotr28;
    import des_pkg::p_key2;
    import des_pkg::p_inverse;

    if (NUM_ROUNDS != 16) begin : g_bad_rounds
        $error("des_round_sequencer: only NUM_ROUNDS = 16 is supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] kc_q, kc_d, kd_q, kd_d;
    logic        dec_q, dec_d;
    logic        rdy_q, rdy_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic [63:0] out_q, out_d;

    logic        accept;
    logic [1:0]  shift_enc, shift_dec;
    logic [27:0] kc_rot, kd_rot;
    logic [47:0] round_key;
    logic [31:0] f_out, r_next;

    assign in_ready  = rdy_q && !abort;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;
    assign round_idx = cnt_q;

    // Encrypt rotates before deriving the key; decrypt uses the current C/D
    // (K16 first) and rotates right afterwards, so both end where they began.
    always_comb begin
        shift_enc = s(SHIFT_SCHED, cnt_q);
        shift_dec = s(SHIFT_SCHED, LAST_ROUND - cnt_q);
        kc_rot    = rotl28(kc_q, shift_enc);
        kd_rot    = rotl28(kd_q, shift_enc);
        round_key = dec_q ? p_key2({kc_q, kd_q}) : p_key2({kc_rot, kd_rot});
        r_next    = l_q ^ f_out;
    end

    des_round_f u_round_f (
        .r (r_q),
        .k (round_key),
        .f (f_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        kc_d        = kc_q;
        kd_d        = kd_q;
        dec_d       = dec_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    l_d     = in[63:32];
                    r_d     = in[31:0];
                    kc_d    = key[27:0];
                    kd_d    = key[55:28];
                    dec_d   = decrypt;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                l_d   = r_q;
                r_d   = r_next;
                kc_d  = dec_q ? rotr28(kc_q, shift_dec) : kc_rot;
                kd_d  = dec_q ? rotr28(kd_q, shift_dec) : kd_rot;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ROUND) begin
                    cnt_d       = 4'd0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_d       = p_inverse({r_next, r_q});
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                out_valid_d = 1'b0;
            end
        endcase

        if (abort) begin
            state_d     = IDLE;
            cnt_d       = 4'd0;
            out_valid_d = 1'b0;
        end

        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            l_q         <= '0;
            r_q         <= '0;
            kc_q        <= '0;
            kd_q        <= '0;
            dec_q       <= 1'b0;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            kc_q        <= kc_d;
            kd_q        <= kd_d;
            dec_q       <= dec_d;
            rdy_q       <= rdy_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Scoreboard bench for des_round_sequencer: directed known-answer vectors plus random round trips.
// Inputs are pre-permuted (IP applied, key already through PC1 with key = {D0, C0}).
module tb_des_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_dat;
    logic [55:0] key_dat;
    logic        decrypt;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_dat;
    logic        busy;
    logic [3:0]  round_idx;

    always #5 clk = ~clk;

    des_round_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_dat),
        .key       (key_dat),
        .decrypt   (decrypt),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_dat),
        .busy      (busy),
        .round_idx (round_idx)
    );

    // Classic DES vector: plaintext 0123456789ABCDEF, key 133457799BBCDFF1.
    localparam logic [63:0] KAT_IN   = 64'hCC00CCFFF0AAF0AA;
    localparam logic [55:0] KAT_KEY  = 56'h556678FF0CCAAF;
    localparam logic [63:0] KAT_CT   = 64'h85E813540F0AB405;
    localparam logic [63:0] KAT_PRE  = 64'h0A4CD99543423234;
    localparam logic [63:0] KAT_PT   = 64'h0123456789ABCDEF;
    localparam logic [63:0] ZERO_CT  = 64'h8CA64DE9C1B123A7;
    localparam int          N_RAND   = 1000;

    localparam int FP_TBL [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25
    };

    typedef struct {
        bit          chk;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_out = '0;

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] o = '0;
        for (int i = 0; i < 64; i++) o[63 - i] = x[64 - FP_TBL[i]];
        return o;
    endfunction

    function automatic logic [63:0] ip(input logic [63:0] y);
        logic [63:0] o = '0;
        for (int i = 0; i < 64; i++) o[64 - FP_TBL[i]] = y[63 - i];
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    task automatic expect_out(input bit chk, input logic [63:0] e, input string n);
        exp_t t;
        t.chk  = chk;
        t.exp  = e;
        t.name = n;
        exp_q.push_back(t);
    endtask

    task automatic send(input logic [63:0] blk, input logic [55:0] k, input logic dec);
        bit done = 0;
        in_dat   = blk;
        key_dat  = k;
        decrypt  = dec;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) fail_bound("accept_timeout");
    endtask

    task automatic wait_out(output int lat, input bit chk_idx);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (chk_idx && k < 16) check("round_idx_run", 64'(round_idx), 64'(k));
            if (out_valid) lat = k;
        end
        if (lat == 0) fail_bound("out_timeout");
    endtask

    task automatic wait_round(input logic [3:0] target);
        bit hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (round_idx == target) hit = 1;
        end
        if (!hit) fail_bound("round_idx_wait");
    endtask

    // Monitor: pops one expectation per completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_dat, '0);
                end else begin
                    e = exp_q.pop_front();
                    last_out = out_dat;
                    if (e.chk) check(e.name, out_dat, e.exp);
                end
            end
        end
    end

    initial begin
        int          lat;
        bit          seen;
        logic [63:0] x, y;
        logic [55:0] k;

        rst_n = 1'b0; in_valid = 1'b0; in_dat = '0; key_dat = '0;
        decrypt = 1'b0; abort = 1'b0; out_ready = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out",       out_dat,        64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Known-answer encrypt with latency and round counter tracking
        expect_out(1, KAT_CT, "kat_encrypt");
        send(KAT_IN, KAT_KEY, 1'b0);
        check("accept_round_idx", 64'(round_idx), 64'd0);
        check("accept_busy",      64'(busy),      64'd1);
        wait_out(lat, 1);
        check("kat_latency", 64'(lat), 64'd16);
        check("done_round_idx", 64'(round_idx), 64'd0);
        @(posedge clk);
        #1;
        check("handshake_out_valid", 64'(out_valid), 64'd0);
        check("handshake_busy",      64'(busy),      64'd0);

        // Known-answer decrypt: pre-output block back to plaintext
        expect_out(1, KAT_PT, "kat_decrypt");
        send(KAT_PRE, KAT_KEY, 1'b1);
        wait_out(lat, 0);
        check("dec_latency", 64'(lat), 64'd16);
        @(posedge clk);
        #1;

        // Random round trips: dec(IP(enc(x))) == FP(x)
        for (int n = 0; n < N_RAND; n++) begin
            x = {$urandom, $urandom};
            k = 56'({$urandom, $urandom});
            expect_out(0, '0, "rt_encrypt");
            send(x, k, 1'b0);
            wait_out(lat, 0);
            @(posedge clk);
            #1;
            y = last_out;
            expect_out(1, fp(x), "rt_decrypt");
            send(ip(y), k, 1'b1);
            wait_out(lat, 0);
            @(posedge clk);
            #1;
        end

        // Backpressure in DONE
        out_ready = 1'b0;
        expect_out(1, KAT_CT, "bp_result");
        send(KAT_IN, KAT_KEY, 1'b0);
        wait_out(lat, 0);
        in_dat = '0; key_dat = '0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_stable", out_dat, KAT_CT);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_busy",      64'(busy),      64'd0);
        check("bp_release_in_ready",  64'(in_ready),  64'd1);

        // Abort mid-RUN
        send(KAT_IN, KAT_KEY, 1'b0);
        wait_round(4'd7);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_round_idx", 64'(round_idx), 64'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_output", 64'(seen), 64'd0);

        // Abort beats an offered block in IDLE
        in_dat = KAT_IN; key_dat = KAT_KEY; in_valid = 1'b1; abort = 1'b1;
        #1;
        check("abort_idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("abort_idle_busy", 64'(busy), 64'd0);
        abort = 1'b0; in_valid = 1'b0;

        expect_out(1, ZERO_CT, "zero_block");
        send('0, '0, 1'b0);
        wait_out(lat, 0);
        @(posedge clk);
        #1;

        // Abort beats the out handshake in DONE
        out_ready = 1'b0;
        send(KAT_IN, KAT_KEY, 1'b0);
        wait_out(lat, 0);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_done_out_valid", 64'(out_valid), 64'd0);
        check("abort_done_busy",      64'(busy),      64'd0);

        // Reset mid-RUN
        send(KAT_PRE, KAT_KEY, 1'b1);
        wait_round(4'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy",      64'(busy),      64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out",       out_dat,        64'd0);
        check("midrst_round_idx", 64'(round_idx), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release_in_ready", 64'(in_ready), 64'd1);

        expect_out(1, KAT_CT, "after_reset_encrypt");
        send(KAT_IN, KAT_KEY, 1'b0);
        wait_out(lat, 0);
        check("after_reset_latency", 64'(lat), 64'd16);

        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
